updown_counter_param: RTL

//   Parametrised synchronous up/down counter. Successor to the fixed 4-bit counters in register-counters.

---
 rtl/updown_counter_param.sv | 73 +++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with enable, parallel load, terminal count and wrap flag.
// Define SATURATE_EN to make the counter hold at its limits instead of wrapping (default: modulo wrap).
module updown_counter_param #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             count,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_next_q;

    assign w_at_max  = (r_q == MAX_Q);
    assign w_at_zero = (r_q == '0);
    assign w_tc      = up ? w_at_max : w_at_zero;

    // Compared one bit wider so MODULUS == 2**WIDTH needs no special case: every din is then in range.
    assign w_load_val = ({1'b0, din} >= MOD_EXT) ? MAX_Q : din;

`ifdef SATURATE_EN
    assign w_inc = w_at_max  ? r_q : r_q + ONE;
    assign w_dec = w_at_zero ? r_q : r_q - ONE;
`else
    assign w_inc = w_at_max  ? '0    : r_q + ONE;
    assign w_dec = w_at_zero ? MAX_Q : r_q - ONE;
`endif

    always_comb begin
        // NOTE: default assigned first so every path drives w_next_q and no latch is inferred.
        w_next_q = r_q;
        if (load) begin
            w_next_q = w_load_val;
        end else if (en) begin
            w_next_q = up ? w_inc : w_dec;
        end
    end

    always_ff @(posedge count or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            // NOTE: non-blocking so both registers sample pre-edge values of r_q and w_tc.
            r_q    <= w_next_q;
            r_wrap <= en & ~load & w_tc;
        end
    end

    assign q    = r_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
